// File: rtl/rv32i_lsu_pkg.sv
// Shared types for the RV32I load/store unit: decoded instruction mnemonics.
package rv32i_lsu_pkg;

  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK
  } RV32I_INSTRUCTION_MNEMONIC_t;

endpackage

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: single-outstanding req/gnt/rvalid data-memory master
// with byte-enable generation, lane replication, load extension and timeout.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  logic                        valid_i,
  input  logic [31:0]                 addr_i,
  input  logic [31:0]                 store_data_i,
  output logic                        stall_o,
  output logic                        done_o,
  output logic [31:0]                 load_data_o,
  output logic                        misaligned_o,
  output logic                        bus_error_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [3:0]                  mem_be_o,
  output logic [31:0]                 mem_addr_o,
  output logic [31:0]                 mem_wdata_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [31:0]                 mem_rdata_i
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE, S_FAULT
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  RV32I_INSTRUCTION_MNEMONIC_t op_q, op_d;
  logic [1:0]                  addr_lo_q, addr_lo_d;
  logic                        mem_req_q, mem_req_d;
  logic                        mem_we_q, mem_we_d;
  logic [3:0]                  mem_be_q, mem_be_d;
  logic [31:0]                 mem_addr_q, mem_addr_d;
  logic [31:0]                 mem_wdata_q, mem_wdata_d;
  logic                        done_q, done_d;
  logic                        misaligned_q, misaligned_d;
  logic                        bus_error_q, bus_error_d;
  logic                        busy_q, busy_d;
  logic [31:0]                 load_data_q, load_data_d;

  logic        is_load_c, is_store_c, is_mem_c, misaligned_c, timeout_hit_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  rbyte_c;
  logic [15:0] rhalf_c;
  logic [31:0] rext_c;

  // Decode of the instruction currently in execute
  always_comb begin
    is_load_c    = 1'b0;
    is_store_c   = 1'b0;
    misaligned_c = 1'b0;
    be_c         = 4'b0000;
    wdata_c      = 32'h0;
    case (mnemonic)
      LB, LBU: begin
        is_load_c = 1'b1;
        be_c      = 4'b0001 << addr_i[1:0];
      end
      LH, LHU: begin
        is_load_c    = 1'b1;
        be_c         = addr_i[1] ? 4'b1100 : 4'b0011;
        misaligned_c = addr_i[0];
      end
      LW: begin
        is_load_c    = 1'b1;
        be_c         = 4'b1111;
        misaligned_c = |addr_i[1:0];
      end
      SB: begin
        is_store_c = 1'b1;
        be_c       = 4'b0001 << addr_i[1:0];
        wdata_c    = {4{store_data_i[7:0]}};
      end
      SH: begin
        is_store_c   = 1'b1;
        be_c         = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c      = {2{store_data_i[15:0]}};
        misaligned_c = addr_i[0];
      end
      SW: begin
        is_store_c   = 1'b1;
        be_c         = 4'b1111;
        wdata_c      = store_data_i;
        misaligned_c = |addr_i[1:0];
      end
      default: ;
    endcase
  end

  assign is_mem_c      = is_load_c | is_store_c;
  assign timeout_hit_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

  // Lane selection and extension of returning read data
  always_comb begin
    rbyte_c = 8'h0;
    case (addr_lo_q)
      2'd0: rbyte_c = mem_rdata_i[7:0];
      2'd1: rbyte_c = mem_rdata_i[15:8];
      2'd2: rbyte_c = mem_rdata_i[23:16];
      2'd3: rbyte_c = mem_rdata_i[31:24];
      default: ;
    endcase
    rhalf_c = addr_lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (op_q)
      LB:      rext_c = {{24{rbyte_c[7]}}, rbyte_c};
      LBU:     rext_c = {24'h0, rbyte_c};
      LH:      rext_c = {{16{rhalf_c[15]}}, rhalf_c};
      LHU:     rext_c = {16'h0, rhalf_c};
      default: rext_c = mem_rdata_i;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
    bus_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_i && is_mem_c) begin
          op_d      = mnemonic;
          addr_lo_d = addr_i[1:0];
          if (misaligned_c) begin
            state_d = S_FAULT;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            mem_we_d    = is_store_c;
            mem_be_d    = be_c;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_wdata_d = is_store_c ? wdata_c : 32'h0;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          cnt_d   = '0;
          state_d = mem_we_q ? S_DONE : S_WAIT;
        end else if (timeout_hit_c) begin
          state_d     = S_DONE;
          bus_error_d = 1'b1;
          if (!mem_we_q) load_data_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          load_data_d = rext_c;
          state_d     = S_DONE;
        end else if (timeout_hit_c) begin
          state_d     = S_DONE;
          bus_error_d = 1'b1;
          load_data_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_req_d    = (state_d == S_REQ);
    busy_d       = (state_d == S_REQ) || (state_d == S_WAIT);
    done_d       = (state_d == S_DONE) || (state_d == S_FAULT);
    misaligned_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= ADDI;
      addr_lo_q    <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      busy_q       <= 1'b0;
      load_data_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      addr_lo_q    <= addr_lo_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
      busy_q       <= busy_d;
      load_data_q  <= load_data_d;
    end
  end

  // Only the accept-cycle stall is combinational so the core freezes immediately
  assign stall_o      = ((state_q == S_IDLE) && valid_i && is_mem_c) || busy_q;
  assign done_o       = done_q;
  assign misaligned_o = misaligned_q;
  assign bus_error_o  = bus_error_q;
  assign load_data_o  = load_data_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed bench for rv32i_lsu; status vector is {stall, done, misaligned, bus_error, req}.
module tb_rv32i_lsu;
  import rv32i_lsu_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
  logic                        valid_i;
  logic [31:0]                 addr_i, store_data_i;
  logic                        stall_o, done_o, misaligned_o, bus_error_o;
  logic [31:0]                 load_data_o;
  logic                        mem_req_o, mem_we_o;
  logic [3:0]                  mem_be_o;
  logic [31:0]                 mem_addr_o, mem_wdata_o;
  logic                        mem_gnt_i, mem_rvalid_i;
  logic [31:0]                 mem_rdata_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_ld;
  logic [4:0]  sts;

  always #5 clk = ~clk;
  assign sts = {stall_o, done_o, misaligned_o, bus_error_o, mem_req_o};

  rv32i_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mnemonic(mnemonic), .valid_i(valid_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .stall_o(stall_o),
    .done_o(done_o), .load_data_o(load_data_o), .misaligned_o(misaligned_o),
    .bus_error_o(bus_error_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic drive(input logic v, input RV32I_INSTRUCTION_MNEMONIC_t m,
                       input logic [31:0] a, input logic [31:0] sd);
    valid_i = v; mnemonic = m; addr_i = a; store_data_i = sd;
  endtask

  task automatic bus(input logic g, input logic rv, input logic [31:0] rd);
    mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, ADDI, 32'h0, 32'h0);
    bus(1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sts !== 5'b00000) begin
      failures++; $display("FAIL reset_status got=%b exp=%b", sts, 5'b00000);
    end
    checks++;
    if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, load_data_o} !== 101'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, load_data_o});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lw();
    @(negedge clk); drive(1'b1, LW, 32'h100, 32'h0); bus(1'b0, 1'b0, 32'h0); #1;
    checks++;
    if (sts !== 5'b10000) begin failures++; $display("FAIL lw_c0 got=%b exp=%b", sts, 5'b10000); end
    @(negedge clk); bus(1'b1, 1'b0, 32'h0); #1;
    checks++;
    if (sts !== 5'b10001) begin failures++; $display("FAIL lw_c1 got=%b exp=%b", sts, 5'b10001); end
    checks++;
    if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b0, 4'hF, 32'h100, 32'h0}) begin
      failures++; $display("FAIL lw_bus got=%h exp=%h", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
                           {1'b0, 4'hF, 32'h100, 32'h0});
    end
    @(negedge clk); bus(1'b0, 1'b1, 32'hDEADBEEF); #1;
    checks++;
    if (sts !== 5'b10000) begin failures++; $display("FAIL lw_c2 got=%b exp=%b", sts, 5'b10000); end
    @(negedge clk); bus(1'b0, 1'b0, 32'h0); #1;
    checks++;
    if (sts !== 5'b01000) begin failures++; $display("FAIL lw_c3 got=%b exp=%b", sts, 5'b01000); end
    checks++;
    if (load_data_o !== 32'hDEADBEEF) begin
      failures++; $display("FAIL lw_data got=%h exp=%h", load_data_o, 32'hDEADBEEF);
    end
    @(negedge clk); drive(1'b0, ADDI, 32'h0, 32'h0); #1;
    checks++;
    if (sts !== 5'b00000) begin failures++; $display("FAIL lw_c4 got=%b exp=%b", sts, 5'b00000); end
    exp_ld = 32'hDEADBEEF;
  endtask

  task automatic test_lb_lbu();
    for (int i = 0; i < 2; i++) begin
      RV32I_INSTRUCTION_MNEMONIC_t m;
      logic [31:0] e;
      m = (i == 0) ? LB : LBU;
      e = (i == 0) ? 32'hFFFFFF80 : 32'h00000080;
      @(negedge clk); drive(1'b1, m, 32'h103, 32'h0); bus(1'b0, 1'b0, 32'h0);
      @(negedge clk); bus(1'b1, 1'b0, 32'h0); #1;
      checks++;
      if ({mem_req_o, mem_be_o, mem_addr_o} !== {1'b1, 4'b1000, 32'h100}) begin
        failures++; $display("FAIL lb_bus%0d got=%h exp=%h", i, {mem_req_o, mem_be_o, mem_addr_o},
                             {1'b1, 4'b1000, 32'h100});
      end
      @(negedge clk); bus(1'b0, 1'b1, 32'h80112233);
      @(negedge clk); bus(1'b0, 1'b0, 32'h0); #1;
      checks++;
      if ({done_o, load_data_o} !== {1'b1, e}) begin
        failures++; $display("FAIL lb_data%0d got=%h exp=%h", i, {done_o, load_data_o}, {1'b1, e});
      end
      @(negedge clk); drive(1'b0, ADDI, 32'h0, 32'h0);
      exp_ld = e;
    end
  endtask

  task automatic test_sh_delayed_gnt();
    @(negedge clk); drive(1'b1, SH, 32'h202, 32'h1234ABCD); bus(1'b0, 1'b0, 32'h0); #1;
    checks++;
    if (sts !== 5'b10000) begin failures++; $display("FAIL sh_c0 got=%b exp=%b", sts, 5'b10000); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); bus(k == 4, 1'b0, 32'h0); #1;
      checks++;
      if (sts !== 5'b10001) begin failures++; $display("FAIL sh_req_c%0d got=%b exp=%b", k, sts, 5'b10001); end
      checks++;
      if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 4'b1100, 32'h200, 32'hABCDABCD}) begin
        failures++; $display("FAIL sh_bus_c%0d got=%h exp=%h", k, {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
                             {1'b1, 4'b1100, 32'h200, 32'hABCDABCD});
      end
    end
    @(negedge clk); bus(1'b0, 1'b0, 32'h0); #1;
    checks++;
    if (sts !== 5'b01000) begin failures++; $display("FAIL sh_done got=%b exp=%b", sts, 5'b01000); end
    checks++;
    if (load_data_o !== exp_ld) begin failures++; $display("FAIL sh_ld_hold got=%h exp=%h", load_data_o, exp_ld); end
    @(negedge clk); drive(1'b0, ADDI, 32'h0, 32'h0); #1;
    checks++;
    if (sts !== 5'b00000) begin failures++; $display("FAIL sh_idle got=%b exp=%b", sts, 5'b00000); end
  endtask

  task automatic test_misaligned();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b1, LW, 32'h101, 32'h0);
      else        drive(1'b1, SH, 32'h301, 32'h5555AAAA);
      bus(1'b0, 1'b0, 32'h0); #1;
      checks++;
      if (sts !== 5'b10000) begin failures++; $display("FAIL mis_c0_%0d got=%b exp=%b", i, sts, 5'b10000); end
      @(negedge clk); #1;
      checks++;
      if (sts !== 5'b01100) begin failures++; $display("FAIL mis_c1_%0d got=%b exp=%b", i, sts, 5'b01100); end
      checks++;
      if (load_data_o !== exp_ld) begin
        failures++; $display("FAIL mis_ld_%0d got=%h exp=%h", i, load_data_o, exp_ld);
      end
      @(negedge clk); drive(1'b0, ADDI, 32'h0, 32'h0); #1;
      checks++;
      if (sts !== 5'b00000) begin failures++; $display("FAIL mis_c2_%0d got=%b exp=%b", i, sts, 5'b00000); end
    end
  endtask

  task automatic test_non_mem();
    @(negedge clk); drive(1'b1, ADD, 32'h100, 32'h0); bus(1'b0, 1'b0, 32'h0); #1;
    checks++;
    if (sts !== 5'b00000) begin failures++; $display("FAIL nonmem_c0 got=%b exp=%b", sts, 5'b00000); end
    @(negedge clk); #1;
    checks++;
    if (sts !== 5'b00000) begin failures++; $display("FAIL nonmem_c1 got=%b exp=%b", sts, 5'b00000); end
    drive(1'b0, ADDI, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    RV32I_INSTRUCTION_MNEMONIC_t ops[5] = '{SB, LH, LHU, SW, LB};
    logic [31:0] adr[5]  = '{32'h11, 32'h42, 32'h40, 32'h300, 32'h1};
    logic [31:0] sd[5]   = '{32'hA5, 32'h0, 32'h0, 32'h11223344, 32'h0};
    logic [31:0] rd[5]   = '{32'h0, 32'h80017FFF, 32'h80017FFF, 32'h0, 32'h00007F00};
    logic [3:0]  be[5]   = '{4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b0010};
    logic [31:0] wd[5]   = '{32'hA5A5A5A5, 32'h0, 32'h0, 32'h11223344, 32'h0};
    logic [31:0] ld[5]   = '{32'h0, 32'hFFFF8001, 32'h00007FFF, 32'h0, 32'h0000007F};
    logic        st[5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], adr[i], sd[i]); bus(1'b0, 1'b0, 32'h0); #1;
      checks++;
      if (sts !== 5'b10000) begin failures++; $display("FAIL b2b_acc%0d got=%b exp=%b", i, sts, 5'b10000); end
      @(negedge clk); bus(1'b1, 1'b0, 32'h0); #1;
      checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !==
          {1'b1, st[i], be[i], {adr[i][31:2], 2'b00}, wd[i]}) begin
        failures++; $display("FAIL b2b_bus%0d got=%h exp=%h", i,
                             {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
                             {1'b1, st[i], be[i], {adr[i][31:2], 2'b00}, wd[i]});
      end
      if (!st[i]) begin
        @(negedge clk); bus(1'b0, 1'b1, rd[i]);
        exp_ld = ld[i];
      end
      @(negedge clk); bus(1'b0, 1'b0, 32'h0); #1;
      checks++;
      if ({sts, load_data_o} !== {5'b01000, exp_ld}) begin
        failures++; $display("FAIL b2b_done%0d got=%h exp=%h", i, {sts, load_data_o}, {5'b01000, exp_ld});
      end
      @(negedge clk);
    end
    drive(1'b0, ADDI, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1'b1, LW, 32'h500, 32'h0); bus(1'b0, 1'b0, 32'h0);
    @(negedge clk); bus(1'b1, 1'b0, 32'h0);
    @(negedge clk); bus(1'b0, 1'b0, 32'h0); #1;
    checks++;
    if (sts !== 5'b10000) begin failures++; $display("FAIL rstmid_wait got=%b exp=%b", sts, 5'b10000); end
    #1; rst = 1'b1; drive(1'b0, ADDI, 32'h0, 32'h0); #1;
    checks++;
    if ({sts, load_data_o} !== {5'b00000, 32'h0}) begin
      failures++; $display("FAIL rstmid_async got=%h exp=%h", {sts, load_data_o}, {5'b00000, 32'h0});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); drive(1'b1, LW, 32'h504, 32'h0);
    @(negedge clk); bus(1'b1, 1'b0, 32'h0); #1;
    checks++;
    if ({mem_req_o, mem_be_o, mem_addr_o} !== {1'b1, 4'hF, 32'h504}) begin
      failures++; $display("FAIL rstmid_req got=%h exp=%h", {mem_req_o, mem_be_o, mem_addr_o},
                           {1'b1, 4'hF, 32'h504});
    end
    @(negedge clk); bus(1'b0, 1'b1, 32'h0BADF00D);
    @(negedge clk); bus(1'b0, 1'b0, 32'h0); #1;
    checks++;
    if ({sts, load_data_o} !== {5'b01000, 32'h0BADF00D}) begin
      failures++; $display("FAIL rstmid_ld got=%h exp=%h", {sts, load_data_o}, {5'b01000, 32'h0BADF00D});
    end
    @(negedge clk); drive(1'b0, ADDI, 32'h0, 32'h0);
  endtask

  task automatic test_timeout();
    @(negedge clk); drive(1'b1, LW, 32'h400, 32'h0); bus(1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      checks++;
      if (sts !== 5'b10001) begin failures++; $display("FAIL to_req_c%0d got=%b exp=%b", k, sts, 5'b10001); end
    end
    @(negedge clk); #1;
    checks++;
    if ({sts, load_data_o} !== {5'b01010, 32'h0}) begin
      failures++; $display("FAIL to_abort got=%h exp=%h", {sts, load_data_o}, {5'b01010, 32'h0});
    end
    @(negedge clk); drive(1'b0, ADDI, 32'h0, 32'h0); bus(1'b1, 1'b1, 32'hFFFFFFFF); #1;
    checks++;
    if (sts !== 5'b00000) begin failures++; $display("FAIL to_late_c0 got=%b exp=%b", sts, 5'b00000); end
    @(negedge clk); bus(1'b0, 1'b0, 32'h0); #1;
    checks++;
    if ({sts, load_data_o} !== {5'b00000, 32'h0}) begin
      failures++; $display("FAIL to_late_c1 got=%h exp=%h", {sts, load_data_o}, {5'b00000, 32'h0});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_ld = 32'h0;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh_delayed_gnt();
    test_misaligned();
    test_non_mem();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
